// File: rtl/chrono_key_ctrl.sv
// Start/pause/clear controller for a chronometer: two debounced active-low keys drive a 3-state FSM.
// Build option: define LONG_PRESS_CLEAR_EN so that key_n[1] clears only after a long hold.
//
// state  | meaning
// -------+--------------------------------------------
// IDLE   | chronometer zeroed/stopped, run = 0
// RUN    | chronometer counting, run = 1
// PAUSED | chronometer holding its value, run = 0
module chrono_key_ctrl #(
    parameter int CLK_HZ        = 50000000,
    parameter int DEBOUNCE_MS   = 20,
    parameter int LONG_PRESS_MS = 1000
) (
    input  logic       clk,
    input  logic       rst_a_n,
    input  logic [1:0] key_n,
    output logic       run,
    output logic       clear,
    output logic [1:0] state
);

    localparam int TICKS_MS = CLK_HZ / 1000;
    localparam int DB_RAW   = TICKS_MS * DEBOUNCE_MS;
    localparam int DB_N     = (DB_RAW < 1) ? 1 : DB_RAW;
    localparam int DB_W     = $clog2(DB_N + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_N - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10
    } state_t;

    logic [1:0]           sync1_q, sync2_q;
    logic [1:0]           deb_q, deb_d;
    logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
    logic                 start_dly_q;
    logic                 start_evt_q, start_evt_d;
    logic                 clr_evt_q, clr_evt_d;
    state_t               state_q, state_d;
    logic                 run_q, run_d;
    logic                 clear_q, clear_d;

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            deb_q       <= 2'b11;
            db_cnt_q    <= '0;
            start_dly_q <= 1'b1;
            start_evt_q <= 1'b0;
            clr_evt_q   <= 1'b0;
        end else begin
            sync1_q     <= key_n;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            db_cnt_q    <= db_cnt_d;
            start_dly_q <= deb_q[0];
            start_evt_q <= start_evt_d;
            clr_evt_q   <= clr_evt_d;
        end
    end

    // Any return to the accepted level before the threshold restarts the count.
    always_comb begin
        deb_d    = deb_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                deb_d[i]    = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    assign start_evt_d = start_dly_q & ~deb_q[0];

`ifdef LONG_PRESS_CLEAR_EN
    localparam int LP_RAW = TICKS_MS * LONG_PRESS_MS;
    localparam int LP_L   = (LP_RAW < 1) ? 1 : LP_RAW;
    localparam int LP_W   = $clog2(LP_L + 1);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LP_L - 1);

    logic [LP_W-1:0] lp_cnt_q, lp_cnt_d;
    logic            lp_done_q, lp_done_d;

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            lp_cnt_q  <= '0;
            lp_done_q <= 1'b0;
        end else begin
            lp_cnt_q  <= lp_cnt_d;
            lp_done_q <= lp_done_d;
        end
    end

    // lp_done_q blocks a second clear until the debounced key is released.
    always_comb begin
        lp_cnt_d  = lp_cnt_q;
        lp_done_d = lp_done_q;
        clr_evt_d = 1'b0;
        if (deb_q[1]) begin
            lp_cnt_d  = '0;
            lp_done_d = 1'b0;
        end else if (!lp_done_q) begin
            if (lp_cnt_q == LP_LAST) begin
                clr_evt_d = 1'b1;
                lp_done_d = 1'b1;
                lp_cnt_d  = '0;
            end else begin
                lp_cnt_d = lp_cnt_q + LP_W'(1);
            end
        end
    end
`else
    logic clr_dly_q;

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            clr_dly_q <= 1'b1;
        end else begin
            clr_dly_q <= deb_q[1];
        end
    end

    assign clr_evt_d = clr_dly_q & ~deb_q[1];
`endif

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            clear_q <= clear_d;
        end
    end

    // Clear outranks a simultaneous start.
    always_comb begin
        state_d = state_q;
        if (clr_evt_q) begin
            state_d = IDLE;
        end else if (start_evt_q) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSED;
                PAUSED:  state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        run_d   = (state_d == RUN);
        clear_d = clr_evt_q;
    end

    assign run   = run_q;
    assign clear = clear_q;
    assign state = state_q;

endmodule

// File: tb/tb_chrono_key_ctrl.sv
// Directed bench for chrono_key_ctrl with CLK_HZ=1000, DEBOUNCE_MS=4, LONG_PRESS_MS=10 (N=4, L=10).
module tb_chrono_key_ctrl;

    logic       clk;
    logic       rst_a_n;
    logic [1:0] key_n;
    logic       run;
    logic       clear;
    logic [1:0] state;

    int n_cmp;
    int n_err;
    int clr_seen;
    int base;

    chrono_key_ctrl #(
        .CLK_HZ        (1000),
        .DEBOUNCE_MS   (4),
        .LONG_PRESS_MS (10)
    ) dut (
        .clk     (clk),
        .rst_a_n (rst_a_n),
        .key_n   (key_n),
        .run     (run),
        .clear   (clear),
        .state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial clr_seen = 0;
    always @(negedge clk) if (clear === 1'b1) clr_seen = clr_seen + 1;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_a_n = 1'b0;
        key_n   = 2'b11;
        tick(3);
        chk("rst_state", int'(state), 0);
        chk("rst_run",   int'(run),   0);
        chk("rst_clear", int'(clear), 0);
        rst_a_n = 1'b1;

        // keys idle
        base = clr_seen;
        tick(20);
        chk("idle_state", int'(state), 0);
        chk("idle_run",   int'(run),   0);
        chk("idle_clr",   clr_seen - base, 0);

        // start / pause / resume, latency N+4 = 8
        key_n[0] = 1'b0;
        tick(7);
        chk("start_pre_state", int'(state), 0);
        chk("start_pre_run",   int'(run),   0);
        tick(1);
        chk("start_state", int'(state), 1);
        chk("start_run",   int'(run),   1);
        key_n[0] = 1'b1;
        tick(12);
        chk("release_state", int'(state), 1);
        key_n[0] = 1'b0;
        tick(7);
        chk("pause_pre_state", int'(state), 1);
        tick(1);
        chk("pause_state", int'(state), 2);
        chk("pause_run",   int'(run),   0);
        key_n[0] = 1'b1;
        tick(12);
        key_n[0] = 1'b0;
        tick(8);
        chk("resume_state", int'(state), 1);
        chk("resume_run",   int'(run),   1);
        tick(30);
        chk("held_state", int'(state), 1);
        key_n[0] = 1'b1;
        tick(12);

        // bounce every 2 cycles never reaches the threshold
        for (int i = 0; i < 10; i++) begin
            key_n[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
        end
        tick(12);
        chk("bounce_state", int'(state), 1);
        chk("bounce_run",   int'(run),   1);

        // reset at debounce count 3 with key still held
        key_n[0] = 1'b0;
        tick(5);
        rst_a_n = 1'b0;
        #1;
        chk("midrst_state", int'(state), 0);
        chk("midrst_run",   int'(run),   0);
        tick(1);
        rst_a_n = 1'b1;
        base = clr_seen;
        tick(7);
        chk("postrst_pre_state", int'(state), 0);
        chk("postrst_pre_clr",   clr_seen - base, 0);
        tick(1);
        chk("postrst_state", int'(state), 1);
        chk("postrst_run",   int'(run),   1);
        key_n[0] = 1'b1;
        tick(12);

`ifndef LONG_PRESS_CLEAR_EN
        // clear and start on the same cycle from RUN
        base  = clr_seen;
        key_n = 2'b00;
        tick(7);
        chk("both_pre_state", int'(state), 1);
        chk("both_pre_clear", int'(clear), 0);
        tick(1);
        chk("both_state", int'(state), 0);
        chk("both_run",   int'(run),   0);
        chk("both_clear", int'(clear), 1);
        tick(1);
        chk("both_clear_end", int'(clear), 0);
        chk("both_clr_cnt",   clr_seen - base, 1);
        key_n = 2'b11;
        tick(12);
        chk("both_rel_state", int'(state), 0);
        chk("both_rel_cnt",   clr_seen - base, 1);

        // clear from IDLE still pulses
        key_n[1] = 1'b0;
        tick(8);
        chk("idle_clear", int'(clear), 1);
        chk("idle_clear_state", int'(state), 0);
        key_n[1] = 1'b1;
        tick(12);
        chk("idle_clear_cnt", clr_seen - base, 2);
`else
        // short hold: debounced key low for 9 cycles only
        base     = clr_seen;
        key_n[1] = 1'b0;
        tick(9);
        key_n[1] = 1'b1;
        tick(30);
        chk("short_clr_cnt", clr_seen - base, 0);
        chk("short_state",   int'(state), 1);

        // long hold: clear at raw edge + N + L + 3
        key_n[1] = 1'b0;
        tick(16);
        chk("long_pre_clear", int'(clear), 0);
        chk("long_pre_state", int'(state), 1);
        tick(1);
        chk("long_clear", int'(clear), 1);
        chk("long_state", int'(state), 0);
        tick(20);
        key_n[1] = 1'b1;
        tick(12);
        chk("long_clr_cnt", clr_seen - base, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/chrono_key_ctrl.md
CHRONO_KEY_CTRL -- requirements
Module: chrono_key_ctrl

Interface
REQ-001 Parameter: CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter: DEBOUNCE_MS, default 20, required stable time of a key before it is accepted.
REQ-003 Parameter: LONG_PRESS_MS, default 1000, hold time for long-press clear; used only when the macro in REQ-024 is defined.
REQ-004 Port: clk, input, 1, single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port: rst_a_n, input, 1, reset; asynchronous assertion, active-low.
REQ-006 Port: key_n, input, 2, raw asynchronous buttons, active-low; key_n[0] is start/pause and key_n[1] is clear.
REQ-007 Port: run, output, 1, level; 1 = the downstream chronometer counts, 0 = it holds.
REQ-008 Port: clear, output, 1, one-cycle pulse; the downstream chronometer zeroes its ms and second counters.
REQ-009 Port: state, output, 2, FSM state encoding: IDLE=00, RUN=01, PAUSED=10.

Function
REQ-010 Each key SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-011 Debounce threshold: N = (CLK_HZ/1000)*DEBOUNCE_MS cycles, using integer arithmetic; N SHALL be at least 1.
- The counter width SHALL be sized by clog2 so that it never wraps before reaching N.
REQ-012 Debounce counter operation:
- Synchronized value equal to the debounced value: the counter resets to 0.
- Values differ: the counter increments.
- Counter reaches N-1 while the values still differ: the debounced value takes the synchronized value and the counter resets.
REQ-013 Bounce: any return of the synchronized value to the debounced value before the threshold SHALL restart the count, with no event produced.
REQ-014 Press event: a one-cycle internal pulse SHALL be generated on each debounced 1->0 transition of a key; release produces no event.
REQ-015 FSM transitions are taken on the cycle after the press event:
- IDLE + start -> RUN.
- RUN + start -> PAUSED.
- PAUSED + start -> RUN.
REQ-016 Clear event in any state: the FSM SHALL go to IDLE and clear SHALL be 1 for exactly one cycle, on the same edge that enters IDLE.
REQ-017 A start event and a clear event in the same cycle: clear SHALL win, the start event is discarded, and the next state is IDLE.
REQ-018 run SHALL be 1 exactly when state is RUN, and it SHALL be registered (no combinational path from key_n).
REQ-019 A key held continuously SHALL produce only one event; a further event requires a debounced release followed by a press.
REQ-020 Latency: from a raw key edge that stays stable, the state change and the clear pulse SHALL occur exactly N+4 cycles later.
- 2 cycles synchronizer, N cycles debounce, 1 cycle event, 1 cycle FSM.

Reset
REQ-021 While rst_a_n=0, the following SHALL hold regardless of clk:
- state = IDLE, run = 0, clear = 0.
- Debounced values = 1 (released), synchronizers = 1, counters = 0.
REQ-022 Reset asserted mid-debounce or mid-hold SHALL discard the partial count; no event SHALL fire after release of reset.
REQ-023 A key already held down when reset is released SHALL produce one event after N+4 cycles.

Configuration
REQ-024 Macro LONG_PRESS_CLEAR_EN controls how key_n[1] clears.
- Defined: key_n[1] SHALL produce a clear event only after the debounced key has stayed pressed for L = (CLK_HZ/1000)*LONG_PRESS_MS further cycles; release before L produces no event, and one hold produces one clear.
- Undefined: the clear event SHALL be the plain press event of REQ-014, and the long-press counter SHALL not be synthesized.

Verification
Common setup: CLK_HZ=1000, DEBOUNCE_MS=4, LONG_PRESS_MS=10 (N=4, L=10).
REQ-025 Reset, then key_n=11 for 20 cycles -> state=00, run=0, clear never asserted.
REQ-026 key_n[0] falls and stays low -> run rises exactly 8 cycles later with state=01; release, then press again -> state=10 and run=0; a third press -> state=01.
REQ-027 key_n[0] toggles every 2 cycles for 20 cycles, then is held high -> no event and state unchanged.
REQ-028 Macro undefined, state RUN, key_n[1] and key_n[0] fall on the same cycle -> after 8 cycles state=00, run=0, and clear is high for exactly 1 cycle.
REQ-029 Macro defined, key_n[1] held for 9 cycles past debounce, then released -> no clear; held for 12 cycles past debounce -> one clear pulse at debounce+10.
REQ-030 rst_a_n pulsed low for 1 cycle at debounce count 3 -> counter restarts and no event fires within the following N+3 cycles.
